// File: rtl/uart16750_host_seq.sv
// uart16750_host_seq
//   Register-bus sequencer for a uart_16750 core. After reset (or a reconfig
//   request) it writes DLL/DLM under DLAB, then LCR, FCR and IER. It then polls
//   LSR and moves bytes between the UART and two byte streams: TX goes into THR
//   and RBR bytes land in a small first-word fall-through RX FIFO.
//
// Ports
//   clk_i, rst_i        UART core clock, asynchronous active-high reset
//   reconfig_i          pulse: rerun the full config sequence at the next poll decision
//   err_clr_i           clears the sticky line_err_o / rx_overrun_o flags
//   tx_data_i/valid_i   TX byte stream in; tx_ready_o marks the accepting cycle
//   rx_data_o/valid_o   RX FIFO head out; rx_ready_i pops it
//   cfg_done_o          high while the config sequence is complete
//   line_err_o          sticky OR of LSR[4:1] (OE, PE, FE, BI)
//   rx_overrun_o        sticky LSR[1]
//   uart_cs_o/wr_o/rd_o, uart_addr_o, uart_wdata_o, uart_rdata_i   UART register bus
//   dbg_state_o         current sequencer state, for observation only
//
// Handshake: a stream byte moves on a rising clock edge where valid and ready
// are both high. Valid never waits for ready; ready may look at valid.
module uart16750_host_seq #(
    parameter logic [15:0] DIVISOR  = 16'd17,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  FCR_VAL  = 8'h00,
    parameter logic [7:0]  IER_VAL  = 8'h00,
    parameter int          RX_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       reconfig_i,
    input  logic       err_clr_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       cfg_done_o,
    output logic       line_err_o,
    output logic       rx_overrun_o,
    output logic       uart_cs_o,
    output logic       uart_wr_o,
    output logic       uart_rd_o,
    output logic [2:0] uart_addr_o,
    output logic [7:0] uart_wdata_o,
    input  logic [7:0] uart_rdata_i,
    output logic [3:0] dbg_state_o
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(RX_DEPTH);

    typedef enum logic [3:0] {
        S_CFG_LCR_DLAB = 4'd0,
        S_CFG_DLL      = 4'd1,
        S_CFG_DLM      = 4'd2,
        S_CFG_LCR      = 4'd3,
        S_CFG_FCR      = 4'd4,
        S_CFG_IER      = 4'd5,
        S_POLL_LSR     = 4'd6,
        S_WRITE_THR    = 4'd7,
        S_READ_RBR     = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;      // access phase P0..P3
    logic        run_q;                 // low for the first cycle after reset so the bus stays idle in reset
    logic [7:0]  thr_q, thr_d;          // latched TX byte
    logic        lsr_dr_q, lsr_dr_d;    // captured LSR[0]
    logic        lsr_thre_q, lsr_thre_d;// captured LSR[5]
    logic        last_rx_q, last_rx_d;  // 1: last contested grant went to RX
    logic        cfg_done_q, cfg_done_d;
    logic        reconf_q, reconf_d;
    logic        line_err_q, line_err_d;
    logic        overrun_q, overrun_d;

    logic [7:0]  fifo_mem [RX_DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] fifo_count;

    // Per-state access description
    logic [2:0]  acc_addr;
    logic [7:0]  acc_wdata;
    logic        acc_read;
    state_t      acc_next;
    logic [1:0]  last_phase;
    logic        acc_end;

    logic        lsr_cap, decide, rbr_push, fifo_pop;
    logic        rx_ok, tx_ok, take_reconf, grant_rx, grant_tx;

    assign fifo_count = wptr_q - rptr_q;

    always_comb begin
        acc_addr  = 3'd0;
        acc_wdata = 8'h00;
        acc_read  = 1'b0;
        acc_next  = S_POLL_LSR;
        case (state_q)
            S_CFG_LCR_DLAB: begin
                acc_addr  = 3'd3;
                acc_wdata = LCR_VAL | 8'h80;
                acc_next  = S_CFG_DLL;
            end
            S_CFG_DLL: begin
                acc_addr  = 3'd0;
                acc_wdata = DIVISOR[7:0];
                acc_next  = S_CFG_DLM;
            end
            S_CFG_DLM: begin
                acc_addr  = 3'd1;
                acc_wdata = DIVISOR[15:8];
                acc_next  = S_CFG_LCR;
            end
            S_CFG_LCR: begin
                acc_addr  = 3'd3;
                acc_wdata = LCR_VAL & 8'h7F;
                acc_next  = S_CFG_FCR;
            end
            S_CFG_FCR: begin
                acc_addr  = 3'd2;
                acc_wdata = FCR_VAL;
                acc_next  = S_CFG_IER;
            end
            S_CFG_IER: begin
                acc_addr  = 3'd1;
                acc_wdata = IER_VAL;
                acc_next  = S_POLL_LSR;
            end
            S_POLL_LSR: begin
                acc_addr  = 3'd5;
                acc_read  = 1'b1;
                acc_next  = S_POLL_LSR;   // replaced by the decision below
            end
            S_WRITE_THR: begin
                acc_addr  = 3'd0;
                acc_wdata = thr_q;
                acc_next  = S_POLL_LSR;
            end
            S_READ_RBR: begin
                acc_addr  = 3'd0;
                acc_read  = 1'b1;
                acc_next  = S_POLL_LSR;
            end
            default: begin
                acc_next  = S_CFG_LCR_DLAB;
            end
        endcase
    end

    assign last_phase = acc_read ? 2'd3 : 2'd2;
    assign acc_end    = run_q && (phase_q == last_phase);
    assign lsr_cap    = run_q && (state_q == S_POLL_LSR) && (phase_q == 2'd2);
    assign decide     = run_q && (state_q == S_POLL_LSR) && (phase_q == 2'd3);
    assign rbr_push   = run_q && (state_q == S_READ_RBR) && (phase_q == 2'd2);
    assign fifo_pop   = rx_valid_o && rx_ready_i;

    // Arbitration works on the LSR captured at the end of P2 and the live tx_valid.
    assign rx_ok       = lsr_dr_q && (fifo_count < DEPTH_C);
    assign tx_ok       = lsr_thre_q && tx_valid_i;
    assign take_reconf = decide && (reconf_q || reconfig_i);
    assign grant_rx    = decide && !take_reconf && rx_ok && (!tx_ok || !last_rx_q);
    assign grant_tx    = decide && !take_reconf && tx_ok && (!rx_ok || last_rx_q);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        thr_d       = thr_q;
        lsr_dr_d    = lsr_dr_q;
        lsr_thre_d  = lsr_thre_q;
        last_rx_d   = last_rx_q;
        cfg_done_d  = cfg_done_q;
        reconf_d    = reconf_q || reconfig_i;
        line_err_d  = err_clr_i ? 1'b0 : line_err_q;
        overrun_d   = err_clr_i ? 1'b0 : overrun_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;

        if (run_q) begin
            if (acc_end) begin
                phase_d = 2'd0;
                state_d = acc_next;
            end else begin
                phase_d = phase_q + 2'd1;
            end
        end

        if (state_q == S_CFG_IER && acc_end) begin
            cfg_done_d = 1'b1;
        end

        // A fresh LSR capture overrides err_clr in the same cycle.
        if (lsr_cap) begin
            lsr_dr_d   = uart_rdata_i[0];
            lsr_thre_d = uart_rdata_i[5];
            if (|uart_rdata_i[4:1]) begin
                line_err_d = 1'b1;
            end
            if (uart_rdata_i[1]) begin
                overrun_d = 1'b1;
            end
        end

        if (decide) begin
            if (take_reconf) begin
                state_d    = S_CFG_LCR_DLAB;
                cfg_done_d = 1'b0;
                reconf_d   = 1'b0;
            end else if (grant_rx) begin
                state_d   = S_READ_RBR;
                last_rx_d = 1'b1;
            end else if (grant_tx) begin
                state_d   = S_WRITE_THR;
                last_rx_d = 1'b0;
                thr_d     = tx_data_i;
            end else begin
                state_d = S_POLL_LSR;
            end
        end

        if (rbr_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_CFG_LCR_DLAB;
            phase_q    <= 2'd0;
            run_q      <= 1'b0;
            thr_q      <= 8'h00;
            lsr_dr_q   <= 1'b0;
            lsr_thre_q <= 1'b0;
            last_rx_q  <= 1'b0;   // RX wins the first contested decision
            cfg_done_q <= 1'b0;
            reconf_q   <= 1'b0;
            line_err_q <= 1'b0;
            overrun_q  <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            run_q      <= 1'b1;
            thr_q      <= thr_d;
            lsr_dr_q   <= lsr_dr_d;
            lsr_thre_q <= lsr_thre_d;
            last_rx_q  <= last_rx_d;
            cfg_done_q <= cfg_done_d;
            reconf_q   <= reconf_d;
            line_err_q <= line_err_d;
            overrun_q  <= overrun_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage only; occupancy is tracked by the reset pointers.
    always_ff @(posedge clk_i) begin
        if (rbr_push) begin
            fifo_mem[wptr_q[AW-1:0]] <= uart_rdata_i;
        end
    end

    // Bus strobes decoded from state/phase; everything is gated by run_q so the
    // bus is idle while reset is applied.
    assign uart_cs_o    = run_q && (acc_read ? (phase_q != 2'd3) : (phase_q != 2'd2));
    assign uart_wr_o    = run_q && !acc_read && (phase_q == 2'd1);
    assign uart_rd_o    = run_q && acc_read && ((phase_q == 2'd1) || (phase_q == 2'd2));
    assign uart_addr_o  = run_q ? acc_addr : 3'd0;
    assign uart_wdata_o = (run_q && !acc_read) ? acc_wdata : 8'h00;

    assign tx_ready_o   = grant_tx;
    assign rx_valid_o   = (fifo_count != '0);
    assign rx_data_o    = rx_valid_o ? fifo_mem[rptr_q[AW-1:0]] : 8'h00;
    assign cfg_done_o   = cfg_done_q;
    assign line_err_o   = line_err_q;
    assign rx_overrun_o = overrun_q;
    assign dbg_state_o  = state_q;

endmodule
